// File: rtl/branch_serial_cmp.sv
// Digit-serial RISC-V branch comparator: consumes XLEN/DW operand digit pairs LSB-first
// and resolves BEQ/BNE/BLT/BGE/BLTU/BGEU, flagging the reserved funct3 encodings.
module branch_serial_cmp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned DW   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    func3,
  input  logic [DW-1:0] rs1_d,
  input  logic [DW-1:0] rs2_d,
  input  logic          d_valid,
  output logic          busy,
  output logic          done,
  output logic          taken,
  output logic          illegal
);

  localparam int unsigned NDig = XLEN / DW;
  localparam int unsigned CntW = (NDig > 1) ? $clog2(NDig) : 1;
  localparam logic [CntW-1:0] LastDig = CntW'(NDig - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state, w_state_d;
  logic [2:0]      r_func3, w_func3_d;
  logic            r_eq, w_eq_d;
  logic            r_lt, w_lt_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_taken, w_taken_d;
  logic            r_illegal, w_illegal_d;

  logic w_dig_eq, w_dig_ltu, w_dig_lts, w_last, w_dig_lt, w_eq_nxt, w_lt_nxt, w_start_bad;

  assign w_dig_eq    = (rs1_d == rs2_d);
  assign w_dig_ltu   = (rs1_d < rs2_d);
  assign w_dig_lts   = ($signed(rs1_d) < $signed(rs2_d));
  assign w_last      = (r_cnt == LastDig);
  // Only the most significant digit carries the sign; funct3[1] selects unsigned.
  assign w_dig_lt    = (w_last && !r_func3[1]) ? w_dig_lts : w_dig_ltu;
  assign w_eq_nxt    = r_eq & w_dig_eq;
  assign w_lt_nxt    = w_dig_lt | (w_dig_eq & r_lt);
  assign w_start_bad = (func3[2:1] == 2'b01);

  function automatic logic decide(input logic [2:0] f, input logic eq, input logic lt);
    unique case (f)
      3'b000:          decide = eq;
      3'b001:          decide = ~eq;
      3'b100, 3'b110:  decide = lt;
      3'b101, 3'b111:  decide = ~lt;
      default:         decide = 1'b0;
    endcase
  endfunction

  always_comb begin
    w_state_d   = r_state;
    w_func3_d   = r_func3;
    w_eq_d      = r_eq;
    w_lt_d      = r_lt;
    w_cnt_d     = r_cnt;
    w_taken_d   = r_taken;
    w_illegal_d = r_illegal;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_func3_d   = func3;
          w_eq_d      = 1'b1;
          w_lt_d      = 1'b0;
          w_cnt_d     = '0;
          w_taken_d   = 1'b0;
          w_illegal_d = w_start_bad;
          w_state_d   = w_start_bad ? StDone : StRun;
        end
      end
      StRun: begin
        if (d_valid) begin
          w_eq_d = w_eq_nxt;
          w_lt_d = w_lt_nxt;
          if (w_last) begin
            w_taken_d = decide(r_func3, w_eq_nxt, w_lt_nxt);
            w_state_d = StDone;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_func3   <= 3'b000;
      r_eq      <= 1'b1;
      r_lt      <= 1'b0;
      r_cnt     <= '0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_func3   <= w_func3_d;
      r_eq      <= w_eq_d;
      r_lt      <= w_lt_d;
      r_cnt     <= w_cnt_d;
      r_taken   <= w_taken_d;
      r_illegal <= w_illegal_d;
    end
  end

  assign busy    = (r_state == StRun);
  assign done    = (r_state == StDone);
  assign taken   = r_taken;
  assign illegal = r_illegal;

endmodule

// File: doc/branch_serial_cmp.md
BRANCH_SERIAL_CMP -- requirements
Module: branch_serial_cmp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand width in bits.
REQ-002 SHALL have parameter DW, default 1, meaning digit width per cycle; legal values 1, 2, 4, 8; XLEN divisible by DW.
REQ-003 SHALL have port clk, input, 1, clock; rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port start, input, 1, begins a compare when the block is IDLE.
REQ-005 SHALL have port func3, input, 3, RISC-V branch funct3, sampled on the accepted start.
REQ-006 SHALL have ports rs1_d and rs2_d, input, DW, current operand digits, LSB-first.
REQ-007 SHALL have port d_valid, input, 1, digits valid this cycle; low stalls without state change.
REQ-008 SHALL have port busy, output, 1, high in RUN.
REQ-009 SHALL have port done, output, 1, single-cycle result strobe.
REQ-010 SHALL have port taken, output, 1, branch decision, held until next accepted start.
REQ-011 SHALL have port illegal, output, 1, funct3 010/011 flag, held like taken.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE -> RUN on start=1; latch func3, clear eq_acc to 1, lt_acc to 0, digit counter to 0.
REQ-014 start with func3 = 010 or 011 SHALL go IDLE -> DONE directly: illegal=1, taken=0, no digits consumed.
REQ-015 In RUN, each cycle with d_valid=1 consumes one digit pair; counter increments; d_valid=0 holds all state.
REQ-016 eq_acc <= eq_acc AND (rs1_d == rs2_d) per consumed digit.
REQ-017 Non-final digit: lt_acc <= (rs1_d <u rs2_d) OR ((rs1_d == rs2_d) AND lt_acc).
REQ-018 Final digit (counter = XLEN/DW-1): same rule, with digit compare signed (MSB = sign) when func3[1]=0, unsigned when func3[1]=1.
REQ-019 After final digit, RUN -> DONE; exactly XLEN/DW consumed digits per compare.
REQ-020 In DONE, done=1 for one cycle, taken/illegal update that cycle; DONE -> IDLE next cycle.
REQ-021 taken: 000 BEQ = eq; 001 BNE = ~eq; 100 BLT / 110 BLTU = lt; 101 BGE / 111 BGEU = ~lt.
REQ-022 start while busy or in DONE SHALL be ignored; no queueing.
REQ-023 Latency start-to-done with no stalls SHALL be XLEN/DW + 1 cycles; each stall cycle adds one.
REQ-024 busy SHALL be 1 exactly in RUN; done SHALL never coincide with busy.
REQ-025 Counter width SHALL be clog2(XLEN/DW), minimum 1 bit; no wrap beyond final digit.

Reset
REQ-026 rst SHALL take priority over all inputs, including mid-compare, returning to IDLE.
REQ-027 On rst: busy=0, done=0, taken=0, illegal=0, eq_acc=1, lt_acc=0, counter=0.
REQ-028 Partial accumulations before rst SHALL not affect any later compare.

Verification
REQ-029 DW=1, XLEN=32: BEQ rs1=rs2=0x1234_5678 -> done on cycle 33 after start, taken=1; BNE same -> taken=0.
REQ-030 DW=4: BLT rs1=0xFFFF_FFFF (-1), rs2=0x0000_0001 -> taken=1; BLTU same operands -> taken=0; BGEU -> taken=1.
REQ-031 DW=8: BGE rs1=rs2=0x8000_0000 -> taken=1 (equality yields GE); BLT -> taken=0; done 5 cycles after start.
REQ-032 DW=2: BEQ with d_valid low 3 cycles mid-stream -> done at 16+1+3 cycles, result identical to unstalled run.
REQ-033 start with func3=011 -> done next cycle, illegal=1, taken=0; start pulsed while busy -> ignored, result unaffected.
REQ-034 rst asserted at digit 10 of a DW=1 BNE -> next cycle busy=0, taken=0; fresh BEQ of equal operands -> taken=1.
